// File: rtl/unstripe_pkg.sv
// Shared types for the two-lane unstriping scheduler.
package unstripe_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESYNC = 2'd2
    } state_e;

endpackage

// File: rtl/unstripe_scheduler_lane_fifo.sv
// Per-lane synchronous FIFO; fullness is judged on occupancy before a same-cycle pop.
module lane_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic              wr_en;
    logic              rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && !full && !flush;
    assign rd_en = pop && !empty && !flush;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/unstripe_scheduler.sv
// Two-lane unstriping scheduler: per-lane FIFOs drained in strict alternation into a
// registered valid/ready output, with a stall watchdog that flushes both lanes on misalignment.
module unstripe_scheduler
    import unstripe_pkg::*;
#(
    parameter int unsigned DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_0,
    input  logic [DATA_W-1:0] lane_0,
    input  logic              valid_1,
    input  logic [DATA_W-1:0] lane_1,
    input  logic              ready_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              active_lane,
    output logic [1:0]        overflow,
    output logic              resync_err
);

    localparam int unsigned CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    lane_e             lane_q, lane_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        ovf_q;

    logic [1:0]        full_v;
    logic [1:0]        empty_v;
    logic [DATA_W-1:0] dout_0, dout_1;
    logic              accept;
    logic              act;
    logic              advance;
    logic              drain_en;
    logic              out_load;
    logic              load;
    logic              flush;

    assign act     = lane_q;
    assign accept  = (state_q != RESYNC);
    assign advance = !valid_q || ready_out;

    lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_0 (
        .clk   (clk),
        .reset (reset),
        .push  (valid_0 && accept),
        .pop   (load && !act),
        .flush (flush),
        .din   (lane_0),
        .full  (full_v[0]),
        .empty (empty_v[0]),
        .dout  (dout_0)
    );

    lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_1 (
        .clk   (clk),
        .reset (reset),
        .push  (valid_1 && accept),
        .pop   (load && act),
        .flush (flush),
        .din   (lane_1),
        .full  (full_v[1]),
        .empty (empty_v[1]),
        .dout  (dout_1)
    );

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        cnt_d    = cnt_q;
        drain_en = 1'b0;
        flush    = 1'b0;
        out_load = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                drain_en = 1'b1;
                if (!empty_v[0]) state_d = RUN;
            end
            RUN: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = RESYNC;
                    lane_d  = LANE0;
                    cnt_d   = '0;
                end else begin
                    drain_en = 1'b1;
                    // Back-pressure holds the count rather than clearing it.
                    if (empty_v[act] && full_v[!act]) begin
                        if (advance && cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            RESYNC: begin
                flush   = 1'b1;
                state_d = IDLE;
                lane_d  = LANE0;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        if (drain_en && advance) begin
            out_load = 1'b1;
            if (!empty_v[act]) begin
                load   = 1'b1;
                lane_d = (lane_q == LANE0) ? LANE1 : LANE0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= LANE0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            if (out_load) begin
                valid_q <= load;
                if (load) data_q <= act ? dout_1 : dout_0;
            end
            ovf_q <= ovf_q | {valid_1 && full_v[1] && accept, valid_0 && full_v[0] && accept};
        end
    end

    assign valid_out   = valid_q;
    assign data_out    = data_q;
    assign active_lane = lane_q;
    assign overflow    = ovf_q;
    assign resync_err  = (state_q == RESYNC);

endmodule

// File: tb/tb_unstripe_scheduler.sv
// Directed bench for unstripe_scheduler with an expected-word scoreboard checked on each handshake.
module tb_unstripe_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_0 = 1'b0;
    logic        valid_1 = 1'b0;
    logic        ready_out = 1'b0;
    logic [31:0] lane_0 = '0;
    logic [31:0] lane_1 = '0;
    logic        valid_out;
    logic [31:0] data_out;
    logic        active_lane;
    logic [1:0]  overflow;
    logic        resync_err;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [31:0] expq[$];

    always #5 clk = ~clk;

    unstripe_scheduler #(.DATA_W(32), .DEPTH(4), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_0     (valid_0),
        .lane_0      (lane_0),
        .valid_1     (valid_1),
        .lane_1      (lane_1),
        .ready_out   (ready_out),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .active_lane (active_lane),
        .overflow    (overflow),
        .resync_err  (resync_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        cyc();
        expq.delete();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        cyc();
        chk("drain_left", expq.size(), 0);
    endtask

    // Every accepted output word must be the next one the scoreboard expects.
    always @(negedge clk) begin
        if (!reset && valid_out && ready_out) begin
            tests++;
            assert (expq.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_word: observed %h expected none", data_out);
            end
            if (expq.size() > 0) chk("merge_order", data_out, expq.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        // 1: reset with both lanes pushing
        reset = 1'b1; ready_out = 1'b1;
        valid_0 = 1'b1; lane_0 = 32'hDEAD_0000;
        valid_1 = 1'b1; lane_1 = 32'hDEAD_0001;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_lane", active_lane, 0);
        chk("rst_resync", resync_err, 0);
        reset = 1'b0; valid_0 = 1'b0; valid_1 = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_no_residue", valid_out, 0);

        // 2: aligned lanes, full throughput
        expq.push_back(32'hA0); expq.push_back(32'hB0);
        expq.push_back(32'hA1); expq.push_back(32'hB1);
        valid_0 = 1'b1; lane_0 = 32'hA0; valid_1 = 1'b1; lane_1 = 32'hB0;
        cyc();
        @(negedge clk);
        chk("t2_pre_valid", valid_out, 0);
        lane_0 = 32'hA1; lane_1 = 32'hB1;
        cyc();
        valid_0 = 1'b0; valid_1 = 1'b0;
        @(negedge clk);
        chk("t2_first_valid", valid_out, 1);
        chk("t2_first_data", data_out, 32'hA0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            @(negedge clk);
            chk("t2_back_to_back", valid_out, 1);
        end
        wait_drain(10);
        @(negedge clk);
        chk("t2_idle_after", valid_out, 0);
        chk("t2_lane_after", active_lane, 0);

        // 3: lane 1 skewed three cycles late
        expq.push_back(32'hC0); expq.push_back(32'hD0);
        expq.push_back(32'hC1); expq.push_back(32'hD1);
        valid_0 = 1'b1; lane_0 = 32'hC0;
        cyc();
        lane_0 = 32'hC1;
        cyc();
        valid_0 = 1'b0;
        @(negedge clk);
        chk("t3_first_data", data_out, 32'hC0);
        cyc();
        @(negedge clk);
        chk("t3_gap_valid", valid_out, 0);
        chk("t3_gap_lane", active_lane, 1);
        valid_1 = 1'b1; lane_1 = 32'hD0;
        cyc();
        lane_1 = 32'hD1;
        cyc();
        valid_1 = 1'b0;
        @(negedge clk);
        chk("t3_lane1_valid", valid_out, 1);
        chk("t3_lane1_data", data_out, 32'hD0);
        wait_drain(10);

        // 4: back-pressure, lane 0 overflow, then recovery via lane 1
        do_reset();
        ready_out = 1'b0;
        expq.push_back(32'hC00);
        expq.push_back(32'hE0); expq.push_back(32'hF1);
        expq.push_back(32'hE1); expq.push_back(32'hF2);
        expq.push_back(32'hE2); expq.push_back(32'hF3);
        expq.push_back(32'hE3); expq.push_back(32'hF4);
        valid_0 = 1'b1; lane_0 = 32'hC00;
        cyc();
        lane_0 = 32'hF1;
        cyc();
        @(negedge clk);
        chk("t4_held_valid", valid_out, 1);
        chk("t4_held_data", data_out, 32'hC00);
        lane_0 = 32'hF2; cyc();
        lane_0 = 32'hF3; cyc();
        lane_0 = 32'hF4; cyc();
        @(negedge clk);
        chk("t4_no_ovf_yet", overflow, 2'b00);
        lane_0 = 32'hF5; cyc();
        valid_0 = 1'b0;
        @(negedge clk);
        chk("t4_ovf_set", overflow, 2'b01);
        for (int k = 0; k < 18; k++) begin
            cyc();
            @(negedge clk);
            chk("t4_stable_data", data_out, 32'hC00);
            chk("t4_no_resync", resync_err, 0);
        end
        ready_out = 1'b1;
        valid_1 = 1'b1; lane_1 = 32'hE0; cyc();
        lane_1 = 32'hE1; cyc();
        lane_1 = 32'hE2; cyc();
        lane_1 = 32'hE3; cyc();
        valid_1 = 1'b0;
        wait_drain(30);
        @(negedge clk);
        chk("t4_ovf_sticky", overflow, 2'b01);
        chk("t4_no_resync_end", resync_err, 0);

        // 5: lane 1 lost, watchdog resync
        do_reset();
        @(negedge clk);
        chk("t4_ovf_cleared", overflow, 2'b00);
        ready_out = 1'b1;
        expq.push_back(32'h50);
        valid_0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            lane_0 = 32'h50 + 32'(k);
            cyc();
        end
        valid_0 = 1'b0;
        for (int k = 0; k < 15; k++) begin
            cyc();
            @(negedge clk);
            chk("t5_no_early_resync", resync_err, 0);
        end
        cyc();
        @(negedge clk);
        chk("t5_resync_pulse", resync_err, 1);
        chk("t5_resync_lane", active_lane, 0);
        chk("t5_resync_valid", valid_out, 0);
        valid_1 = 1'b1; lane_1 = 32'h0DD;
        cyc();
        valid_1 = 1'b0;
        @(negedge clk);
        chk("t5_pulse_once", resync_err, 0);
        chk("t5_ovf", overflow, 2'b00);
        expq.push_back(32'h60); expq.push_back(32'h61);
        valid_1 = 1'b1; lane_1 = 32'h61;
        cyc();
        valid_1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            @(negedge clk);
            chk("t5_no_lane_skip", valid_out, 0);
        end
        valid_0 = 1'b1; lane_0 = 32'h60;
        cyc();
        valid_0 = 1'b0;
        wait_drain(10);

        // 6: reset while a word is held under back-pressure
        do_reset();
        ready_out = 1'b0;
        expq.push_back(32'h70);
        valid_0 = 1'b1; lane_0 = 32'h70; valid_1 = 1'b1; lane_1 = 32'h80;
        cyc();
        lane_0 = 32'h71; valid_1 = 1'b0;
        cyc();
        valid_0 = 1'b0;
        @(negedge clk);
        chk("t6_held_valid", valid_out, 1);
        chk("t6_held_data", data_out, 32'h70);
        reset = 1'b1;
        cyc();
        @(negedge clk);
        chk("t6_rst_valid", valid_out, 0);
        chk("t6_rst_data", data_out, 0);
        chk("t6_rst_lane", active_lane, 0);
        expq.delete();
        reset = 1'b0;
        ready_out = 1'b1;
        expq.push_back(32'h90); expq.push_back(32'h91);
        valid_1 = 1'b1; lane_1 = 32'h91;
        cyc();
        valid_1 = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        chk("t6_fifos_empty", valid_out, 0);
        valid_0 = 1'b1; lane_0 = 32'h90;
        cyc();
        valid_0 = 1'b0;
        wait_drain(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
